mem_port_arbiter: RTL and testbench

//  Shares the single memory port between a read client (K/V/Q loader) and a write client (O drainer).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_tag_fifo.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizes for the memory-port arbiter slice: bus widths,
// memory command encoding, tag type and the grant identifier.
package mem_port_arbiter_pkg;

  localparam int ADDR_W       = 32;
  localparam int BLOCK_W      = 64;
  localparam int TAG_W        = 4;
  localparam int NUM_MEM_TAGS = 15;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order FIFO of outstanding load tags. The head is visible combinationally
// so the return path can match an incoming data tag in the same cycle.
module mem_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = NUM_MEM_TAGS + 1,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0] slot_reg [DEPTH];
  logic [PTR_W-1:0] head_ptr_reg;
  logic [PTR_W-1:0] tail_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // tag storage; contents need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (push) begin
      slot_reg[tail_ptr_reg] <= push_tag;
    end
  end

  // pointers wrap at DEPTH (not necessarily a power of two); push+pop keeps count
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        tail_ptr_reg <= (tail_ptr_reg == LAST_PTR) ? '0 : tail_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        head_ptr_reg <= (head_ptr_reg == LAST_PTR) ? '0 : head_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = slot_reg[head_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between a load client and a store client.
// Round-robin on ties, one command per cycle, load data returned in issue order.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = NUM_MEM_TAGS,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req_vld,
  input  logic [ADDR_W-1:0]  rd_req_addr,
  output logic               rd_req_rdy,
  input  logic               wr_req_vld,
  input  logic [ADDR_W-1:0]  wr_req_addr,
  input  logic [BLOCK_W-1:0] wr_req_data,
  output logic               wr_req_rdy,
  output logic               rd_rsp_vld,
  output logic [BLOCK_W-1:0] rd_rsp_data,
  output MEM_COMMAND         proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
  input  logic [BLOCK_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]   mem2proc_data_tag,
  output logic [CNT_W-1:0]   outstanding,
  output logic               tag_err
);

  grant_e             last_grant_reg;
  grant_e             last_grant_next;
  logic               rd_elig;
  logic               wr_elig;
  logic               gnt_rd;
  logic               gnt_wr;
  logic               tag_ok;
  logic               rd_acc;
  logic               wr_acc;
  logic [TAG_W-1:0]   fifo_head;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               data_hit;
  logic               data_bad;
  logic               rsp_vld_reg;
  logic [BLOCK_W-1:0] rsp_data_reg;
  logic               tag_err_reg;

  // Eligibility uses the registered count, so a same-cycle pop never unblocks a load.
  assign rd_elig = rd_req_vld && (fifo_count < CNT_W'(MAX_OUTSTANDING));
  assign wr_elig = wr_req_vld;
  assign tag_ok  = (mem2proc_transaction_tag != '0);

  // Grants are forced off during reset so the port stays idle.
  assign gnt_rd = rst && rd_elig && (!wr_elig || (last_grant_reg == GNT_WR));
  assign gnt_wr = rst && wr_elig && (!rd_elig || (last_grant_reg == GNT_RD));
  assign rd_acc = gnt_rd && tag_ok;
  assign wr_acc = gnt_wr && tag_ok;

  // round-robin state register; a rejected command leaves the priority unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= GNT_WR;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // next-state: remember whichever client was actually accepted
  always_comb begin
    last_grant_next = last_grant_reg;
    if (rd_acc) begin
      last_grant_next = GNT_RD;
    end else if (wr_acc) begin
      last_grant_next = GNT_WR;
    end
  end

  // drive the granted request onto the memory port in the same cycle
  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (gnt_rd) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = rd_req_addr;
    end else if (gnt_wr) begin
      proc2mem_command = MEM_STORE;
      proc2mem_addr    = wr_req_addr;
      proc2mem_data    = wr_req_data;
    end
  end

  assign rd_req_rdy = rd_acc;
  assign wr_req_rdy = wr_acc;

  // Returns against an empty FIFO are stale tags from before a reset and are ignored.
  assign data_hit = !fifo_empty && (mem2proc_data_tag != '0) && (mem2proc_data_tag == fifo_head);
  assign data_bad = !fifo_empty && (mem2proc_data_tag != '0) && (mem2proc_data_tag != fifo_head);

  mem_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING + 1),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_acc),
    .push_tag (mem2proc_transaction_tag),
    .pop      (data_hit),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // register in-order load data for a one-cycle response pulse; latch tag errors
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_vld_reg  <= 1'b0;
      rsp_data_reg <= '0;
      tag_err_reg  <= 1'b0;
    end else begin
      rsp_vld_reg <= data_hit;
      if (data_hit) begin
        rsp_data_reg <= mem2proc_data;
      end
      if (data_bad) begin
        tag_err_reg <= 1'b1;
      end
    end
  end

  assign rd_rsp_vld  = rsp_vld_reg;
  assign rd_rsp_data = rsp_data_reg;
  assign outstanding = fifo_count;
  assign tag_err     = tag_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random
// traffic, all checked against an in-order queue model of the arbiter rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXO = NUM_MEM_TAGS;
  localparam int CW   = $clog2(MAXO + 1);

  logic         clk;
  logic         rst;
  logic         rd_req_vld;
  logic [31:0]  rd_req_addr;
  logic         rd_req_rdy;
  logic         wr_req_vld;
  logic [31:0]  wr_req_addr;
  logic [63:0]  wr_req_data;
  logic         wr_req_rdy;
  logic         rd_rsp_vld;
  logic [63:0]  rd_rsp_data;
  MEM_COMMAND   proc2mem_command;
  logic [31:0]  proc2mem_addr;
  logic [63:0]  proc2mem_data;
  logic [3:0]   mem2proc_transaction_tag;
  logic [63:0]  mem2proc_data;
  logic [3:0]   mem2proc_data_tag;
  logic [CW-1:0] outstanding;
  logic         tag_err;

  int checks;
  int errors;

  // reference model state
  int          q[$];        // tags in flight, issue order
  int          mem_q[$];    // tags the memory side still owes
  bit          m_rsp_vld;
  bit          m_err;
  bit          m_last_wr;
  logic [63:0] m_rsp_data;
  int          next_tag;

  // samples of the last tick
  MEM_COMMAND  s_cmd;
  logic        s_rd_rdy;
  logic        s_wr_rdy;
  logic [63:0] s_data;
  bit          a_rd;
  bit          a_wr;

  mem_port_arbiter dut (
    .clk                      (clk),
    .rst                      (rst),
    .rd_req_vld               (rd_req_vld),
    .rd_req_addr              (rd_req_addr),
    .rd_req_rdy               (rd_req_rdy),
    .wr_req_vld               (wr_req_vld),
    .wr_req_addr              (wr_req_addr),
    .wr_req_data              (wr_req_data),
    .wr_req_rdy               (wr_req_rdy),
    .rd_rsp_vld               (rd_rsp_vld),
    .rd_rsp_data              (rd_rsp_data),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .outstanding              (outstanding),
    .tag_err                  (tag_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_req_vld               = 1'b0;
    wr_req_vld               = 1'b0;
    mem2proc_transaction_tag = '0;
    mem2proc_data_tag        = '0;
    mem2proc_data            = '0;
  endtask

  // Called just after a negedge with inputs set: check, model one posedge, advance.
  task automatic tick();
    bit          e_rd, e_wr, g_rd, g_wr, tok, hit;
    MEM_COMMAND  ec;
    logic [31:0] ea;
    logic [63:0] ed;
    #1;
    s_cmd    = proc2mem_command;
    s_rd_rdy = rd_req_rdy;
    s_wr_rdy = wr_req_rdy;
    s_data   = proc2mem_data;
    a_rd     = 1'b0;
    a_wr     = 1'b0;
    chk("tag_err", tag_err, m_err);
    chk("rsp_vld", rd_rsp_vld, m_rsp_vld);
    if (m_rsp_vld) chk("rsp_data", rd_rsp_data, m_rsp_data);
    chk("outstanding", outstanding, q.size());
    if (!rst) begin
      chk("rst_cmd", proc2mem_command, MEM_NONE);
      chk("rst_addr", proc2mem_addr, 0);
      chk("rst_data", proc2mem_data, 0);
      chk("rst_rd_rdy", rd_req_rdy, 0);
      chk("rst_wr_rdy", wr_req_rdy, 0);
      q.delete();
      m_err      = 1'b0;
      m_last_wr  = 1'b1;
      m_rsp_vld  = 1'b0;
      m_rsp_data = '0;
    end else begin
      e_rd = rd_req_vld && (q.size() < MAXO);
      e_wr = wr_req_vld;
      g_rd = e_rd && (!e_wr || m_last_wr);
      g_wr = e_wr && !g_rd;
      tok  = (mem2proc_transaction_tag != 0);
      ec   = g_rd ? MEM_LOAD : (g_wr ? MEM_STORE : MEM_NONE);
      ea   = g_rd ? rd_req_addr : (g_wr ? wr_req_addr : 32'h0);
      ed   = g_wr ? wr_req_data : 64'h0;
      chk("cmd", proc2mem_command, ec);
      chk("addr", proc2mem_addr, ea);
      chk("data", proc2mem_data, ed);
      chk("rd_rdy", rd_req_rdy, g_rd && tok);
      chk("wr_rdy", wr_req_rdy, g_wr && tok);
      hit = 1'b0;
      if (mem2proc_data_tag != 0 && q.size() > 0) begin
        if (int'(mem2proc_data_tag) == q[0]) begin
          hit = 1'b1;
          void'(q.pop_front());
          m_rsp_data = mem2proc_data;
        end else begin
          m_err = 1'b1;
        end
      end
      m_rsp_vld = hit;
      a_rd = g_rd && tok;
      a_wr = g_wr && tok;
      if (a_rd || a_wr) m_last_wr = a_wr;
      if (a_rd) begin
        q.push_back(int'(mem2proc_transaction_tag));
        mem_q.push_back(int'(mem2proc_transaction_tag));
        next_tag = (int'(mem2proc_transaction_tag) % MAXO) + 1;
        $display("LOAD   addr=%h tag=%0d", rd_req_addr, mem2proc_transaction_tag);
      end
      if (a_wr) $display("STORE  addr=%h data=%h", wr_req_addr, wr_req_data);
      if (hit) $display("RETURN tag=%0d data=%h", mem2proc_data_tag, mem2proc_data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    idle();
    rd_req_vld               = 1'b1;
    wr_req_vld               = 1'b1;
    mem2proc_transaction_tag = 4'd1;
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
    idle();
    mem_q.delete();
  endtask

  task automatic ret_head();
    if (mem_q.size() > 0) begin
      mem2proc_data_tag = 4'(mem_q.pop_front());
      mem2proc_data     = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mem_q.size() > 0; i++) begin
      idle();
      ret_head();
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    next_tag    = 1;
    a_rd        = 1'b0;
    a_wr        = 1'b0;
    rd_req_addr = '0;
    wr_req_addr = '0;
    wr_req_data = '0;
    idle();
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    m_err = 1'b0; m_last_wr = 1'b1; m_rsp_vld = 1'b0; m_rsp_data = '0;
    do_reset(2);

    // 1: single load, data returned four cycles later
    idle();
    rd_req_vld = 1'b1; rd_req_addr = 32'h100; mem2proc_transaction_tag = 4'd3;
    tick();
    chk("t1_rd_rdy", s_rd_rdy, 1);
    chk("t1_cmd", s_cmd, MEM_LOAD);
    chk("t1_out1", outstanding, 1);
    idle();
    repeat (3) tick();
    mem2proc_data_tag = 4'd3; mem2proc_data = 64'hAB;
    tick();
    mem_q.delete();
    idle();
    chk("t1_rsp_vld", rd_rsp_vld, 1);
    chk("t1_rsp_data", rd_rsp_data, 64'hAB);
    chk("t1_out0", outstanding, 0);
    tick();
    chk("t1_rsp_pulse", rd_rsp_vld, 0);

    // 2: both clients valid for four cycles alternate, load first after reset
    do_reset(2);
    rd_req_vld = 1'b1; rd_req_addr = 32'h200;
    wr_req_vld = 1'b1; wr_req_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      mem2proc_transaction_tag = 4'(next_tag);
      wr_req_data = 64'h1000 + 64'(i);
      tick();
      chk("t2_cmd", s_cmd, (i % 2 == 0) ? MEM_LOAD : MEM_STORE);
      if (i % 2 == 1) chk("t2_store_data", s_data, 64'h1000 + 64'(i));
    end
    drain();

    // 3: two rejections then acceptance; only one tag recorded
    idle();
    rd_req_vld = 1'b1; rd_req_addr = 32'h400;
    repeat (2) begin
      mem2proc_transaction_tag = '0;
      tick();
      chk("t3_rej_rdy", s_rd_rdy, 0);
      chk("t3_rej_cmd", s_cmd, MEM_LOAD);
    end
    mem2proc_transaction_tag = 4'(next_tag);
    tick();
    chk("t3_acc_rdy", s_rd_rdy, 1);
    chk("t3_out", outstanding, 1);
    drain();

    // 4: fill to MAX_OUTSTANDING, loads stall while stores continue
    idle();
    rd_req_vld = 1'b1; wr_req_vld = 1'b1;
    for (int i = 0; i < 60 && q.size() < MAXO; i++) begin
      rd_req_addr = 32'h1000 + 32'(i * 8);
      wr_req_addr = 32'h2000 + 32'(i * 8);
      wr_req_data = {$urandom, $urandom};
      mem2proc_transaction_tag = 4'(next_tag);
      tick();
    end
    chk("t4_full", outstanding, MAXO);
    repeat (2) begin
      mem2proc_transaction_tag = 4'(next_tag);
      tick();
      chk("t4_stall_rd", s_rd_rdy, 0);
      chk("t4_store_cmd", s_cmd, MEM_STORE);
      chk("t4_store_rdy", s_wr_rdy, 1);
    end
    wr_req_vld = 1'b0;
    ret_head();
    mem2proc_transaction_tag = 4'(next_tag);
    tick();
    chk("t4_pop_no_unblock", s_rd_rdy, 0);
    chk("t4_pop_cmd", s_cmd, MEM_NONE);
    mem2proc_data_tag = '0;
    mem2proc_transaction_tag = 4'(next_tag);
    tick();
    chk("t4_unblocked", s_rd_rdy, 1);
    chk("t4_unblocked_cmd", s_cmd, MEM_LOAD);
    drain();

    // 5: out-of-order return flags an error and drops the data
    do_reset(2);
    rd_req_vld = 1'b1; rd_req_addr = 32'h500; mem2proc_transaction_tag = 4'd5;
    tick();
    rd_req_addr = 32'h540; mem2proc_transaction_tag = 4'd6;
    tick();
    idle();
    mem_q.delete();
    mem2proc_data_tag = 4'd6; mem2proc_data = 64'h66;
    tick();
    idle();
    chk("t5_err", tag_err, 1);
    chk("t5_no_rsp", rd_rsp_vld, 0);
    chk("t5_out2", outstanding, 2);
    mem2proc_data_tag = 4'd5; mem2proc_data = 64'h55;
    tick();
    idle();
    chk("t5_rsp5", rd_rsp_vld, 1);
    chk("t5_data5", rd_rsp_data, 64'h55);
    mem2proc_data_tag = 4'd6; mem2proc_data = 64'h66;
    tick();
    idle();
    chk("t5_data6", rd_rsp_data, 64'h66);
    chk("t5_err_sticky", tag_err, 1);
    tick();

    // 6: reset with loads in flight; stale returns are ignored
    do_reset(2);
    rd_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req_addr = 32'h600 + 32'(i * 64);
      mem2proc_transaction_tag = 4'(9 + i);
      tick();
    end
    chk("t6_out3", outstanding, 3);
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      mem2proc_data_tag = 4'(9 + i); mem2proc_data = 64'hDEAD;
      tick();
      chk("t6_no_rsp", rd_rsp_vld, 0);
    end
    idle();
    tick();
    chk("t6_no_rsp_end", rd_rsp_vld, 0);
    chk("t6_err", tag_err, 0);
    chk("t6_out0", outstanding, 0);

    // random traffic; requests held stable until accepted
    do_reset(2);
    next_tag = 1;
    a_rd = 1'b0; a_wr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!rd_req_vld || a_rd) begin
        rd_req_vld  = ($urandom_range(0, 3) != 0);
        rd_req_addr = $urandom & ~32'h7;
      end
      if (!wr_req_vld || a_wr) begin
        wr_req_vld  = ($urandom_range(0, 2) == 0);
        wr_req_addr = $urandom & ~32'h7;
        wr_req_data = {$urandom, $urandom};
      end
      mem2proc_transaction_tag = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'(next_tag);
      mem2proc_data_tag = '0;
      mem2proc_data     = '0;
      if ($urandom_range(0, 2) == 0) ret_head();
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
